// File: rtl/imem_loader.sv
// Instruction-memory loader: pulls a length-prefixed, XOR-checksummed byte
// stream and writes it as 16-bit words into instruction memory while the
// CPU is held off fetch.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | after reset, waiting for load_start; CPU held
// S_LEN_HI  | expecting word-count high byte
// S_LEN_LO  | expecting word-count low byte; range-checked against MEM_WORDS
// S_DATA_HI | expecting high byte of the next instruction word
// S_DATA_LO | expecting low byte; completes the word and queues the write
// S_CHECK   | expecting the checksum byte
// S_DONE    | session good; CPU released
// S_ERR     | length overflow or checksum mismatch; CPU stays held
module imem_loader #(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load_start,
  input  logic          i_in_valid,
  input  logic [7:0]    i_in_data,
  output logic          o_in_ready,
  output logic          o_imem_we,
  output logic [AW-1:0] o_imem_waddr,
  output logic [15:0]   o_imem_wdata,
  output logic          o_cpu_hold,
  output logic          o_load_done,
  output logic          o_load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] LP_MAX_WORDS = 17'(MEM_WORDS);

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_hi;
  logic [15:0]   r_left;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_csum;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [15:0]   r_wdata;

  logic          w_accept;
  logic          w_start;
  logic [15:0]   w_len;
  logic          w_len_too_big;
  logic          w_last_word;

  assign w_accept      = i_in_valid & o_in_ready;
  assign w_start       = i_load_start &
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len         = {r_hi, i_in_data};
  assign w_len_too_big = {1'b0, w_len} > LP_MAX_WORDS;
  // r_left counts words still to come, so 1 means this DATA_LO closes the payload
  assign w_last_word   = (r_left == 16'd1);

  assign o_imem_we    = r_we;
  assign o_imem_waddr = r_waddr;
  assign o_imem_wdata = r_wdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_cpu_hold   = 1'b1;
    o_load_done  = 1'b0;
    o_load_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          if (w_len_too_big)      w_state_next = S_ERR;
          else if (w_len == '0)   w_state_next = S_CHECK;
          else                    w_state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_next = w_last_word ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_next = (i_in_data == r_csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        o_cpu_hold  = 1'b0;
        o_load_done = 1'b1;
        if (w_start) w_state_next = S_LEN_HI;
      end
      S_ERR: begin
        o_load_error = 1'b1;
        if (w_start) w_state_next = S_LEN_HI;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // byte capture, word counter, address, checksum and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_left  <= '0;
      r_addr  <= '0;
      r_csum  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_left <= '0;
        r_addr <= '0;
        r_csum <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN_HI:  r_hi <= i_in_data;
          S_LEN_LO:  r_left <= w_len;
          S_DATA_HI: begin
            r_hi   <= i_in_data;
            r_csum <= r_csum ^ i_in_data;
          end
          S_DATA_LO: begin
            r_csum  <= r_csum ^ i_in_data;
            r_we    <= 1'b1;
            r_wdata <= {r_hi, i_in_data};
            r_waddr <= r_addr;
            r_addr  <= r_addr + AW'(2);
            r_left  <= r_left - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized sessions
// compared against a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_load_start;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_imem_we;
  logic [8:0]  o_imem_waddr;
  logic [15:0] o_imem_wdata;
  logic        o_cpu_hold;
  logic        o_load_done;
  logic        o_load_error;

  imem_loader #(.MEM_WORDS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_waddr (o_imem_waddr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_load_done  (o_load_done),
    .o_load_error (o_load_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [24:0] wq[$];        // observed writes {addr, data}
  int          wcyc[$];      // cycle of each observed write
  logic [7:0]  s_bytes[$];   // stream under test
  logic [24:0] m_writes[$];  // model writes
  bit          m_done;
  int          m_consumed;

  always @(posedge clk) cyc++;

  // observe the write port mid-cycle
  always @(negedge clk) begin
    if (o_imem_we === 1'b1) begin
      wq.push_back({o_imem_waddr, o_imem_wdata});
      wcyc.push_back(cyc);
    end
  end

  // reference model: interpret the stream by its format rules
  function automatic void model();
    int n;
    logic [7:0] x;
    m_writes.delete();
    n = {s_bytes[0], s_bytes[1]};
    if (n > 256) begin
      m_done = 1'b0;
      m_consumed = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      m_writes.push_back({9'(2 * k), s_bytes[2 + 2 * k], s_bytes[3 + 2 * k]});
      x = x ^ s_bytes[2 + 2 * k] ^ s_bytes[3 + 2 * k];
    end
    m_consumed = 2 + 2 * n + 1;
    m_done = (s_bytes[2 + 2 * n] == x);
  endfunction

  function automatic bit writes_match();
    if (wq.size() != m_writes.size()) return 1'b0;
    foreach (wq[k]) if (wq[k] !== m_writes[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    s_bytes.delete();
    s_bytes.push_back(n[15:8]);
    s_bytes.push_back(n[7:0]);
    x = 8'h00;
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      s_bytes.push_back(b);
      x = x ^ b;
    end
    s_bytes.push_back(good ? x : (x ^ 8'(1 + $urandom_range(254))));
  endtask

  task automatic do_start();
    wq.delete();
    wcyc.delete();
    @(negedge clk);
    i_load_start = 1'b1;
    @(negedge clk);
    i_load_start = 1'b0;
  endtask

  // offers bytes while the loader is ready; stops when it drops in_ready
  task automatic drive(input int n_send, input int gap_pct, input int start_at, output int sent);
    int budget;
    bit pulsed;
    budget = 0;
    pulsed = 1'b0;
    sent = 0;
    while (sent < n_send) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      i_load_start = 1'b0;
      if (o_in_ready !== 1'b1) break;
      if (sent == start_at && !pulsed) begin
        i_load_start = 1'b1;
        pulsed = 1'b1;
      end
      if ($urandom_range(99) >= gap_pct) begin
        i_in_valid = 1'b1;
        i_in_data = s_bytes[sent];
      end
      @(posedge clk);
      if (i_in_valid) sent++;
      budget++;
      if (budget > 20000) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout sent=%0d wanted=%0d", sent, n_send);
        break;
      end
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    i_load_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_load_start = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = 8'h00;
    #1;
    checks++;
    if ({o_in_ready, o_imem_we, o_imem_waddr, o_imem_wdata, o_cpu_hold, o_load_done, o_load_error}
        !== {1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
               o_in_ready, o_imem_we, o_imem_waddr, o_imem_wdata, o_cpu_hold, o_load_done, o_load_error);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_in_ready, o_cpu_hold, o_load_done, o_load_error} !== 4'b0100) begin
      failures++;
      $display("FAIL idle_after_reset got rdy=%b hold=%b done=%b err=%b expected 0 1 0 0",
               o_in_ready, o_cpu_hold, o_load_done, o_load_error);
    end
  endtask

  task automatic test_directed_good();
    int sent;
    s_bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    do_start();
    checks++;
    if ({o_in_ready, o_cpu_hold, o_load_done, o_load_error} !== 4'b1100) begin
      failures++;
      $display("FAIL start_state got rdy=%b hold=%b done=%b err=%b expected 1 1 0 0",
               o_in_ready, o_cpu_hold, o_load_done, o_load_error);
    end
    drive(s_bytes.size(), 0, -1, sent);
    checks++;
    if (wq.size() !== 2) begin
      failures++;
      $display("FAIL good_write_count got %0d expected 2", wq.size());
    end
    checks++;
    if (wq[0] !== {9'h000, 16'h1234} || wq[1] !== {9'h002, 16'hABCD}) begin
      failures++;
      $display("FAIL good_writes got %h %h expected 0001234 002abcd", wq[0], wq[1]);
    end
    checks++;
    if ({o_load_done, o_load_error, o_cpu_hold, o_in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL good_final got done=%b err=%b hold=%b rdy=%b expected 1 0 0 0",
               o_load_done, o_load_error, o_cpu_hold, o_in_ready);
    end
  endtask

  task automatic test_bad_checksum();
    int sent;
    s_bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    do_start();
    drive(s_bytes.size(), 0, -1, sent);
    checks++;
    if (wq.size() !== 2 || wq[0] !== {9'h000, 16'h1234} || wq[1] !== {9'h002, 16'hABCD}) begin
      failures++;
      $display("FAIL bad_csum_writes got n=%0d %h %h expected 2 writes", wq.size(), wq[0], wq[1]);
    end
    checks++;
    if ({o_load_done, o_load_error, o_cpu_hold, o_in_ready} !== 4'b0110) begin
      failures++;
      $display("FAIL bad_csum_final got done=%b err=%b hold=%b rdy=%b expected 0 1 1 0",
               o_load_done, o_load_error, o_cpu_hold, o_in_ready);
    end
  endtask

  task automatic test_len_overflow();
    int sent;
    s_bytes = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    drive(s_bytes.size(), 0, -1, sent);
    checks++;
    if (sent !== 2) begin
      failures++;
      $display("FAIL overflow_bytes_taken got %0d expected 2", sent);
    end
    checks++;
    if (wq.size() !== 0 || {o_load_error, o_load_done, o_cpu_hold} !== 3'b101) begin
      failures++;
      $display("FAIL overflow_final got writes=%0d err=%b done=%b hold=%b expected 0 1 0 1",
               wq.size(), o_load_error, o_load_done, o_cpu_hold);
    end
  endtask

  task automatic test_zero_len();
    int sent;
    s_bytes = '{8'h00, 8'h00, 8'h00};
    do_start();
    drive(s_bytes.size(), 0, -1, sent);
    checks++;
    if (wq.size() !== 0 || {o_load_done, o_load_error, o_cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL zero_len_good got writes=%0d done=%b err=%b hold=%b expected 0 1 0 0",
               wq.size(), o_load_done, o_load_error, o_cpu_hold);
    end
    s_bytes = '{8'h00, 8'h00, 8'h01};
    do_start();
    drive(s_bytes.size(), 0, -1, sent);
    checks++;
    if (wq.size() !== 0 || {o_load_done, o_load_error, o_cpu_hold} !== 3'b011) begin
      failures++;
      $display("FAIL zero_len_bad got writes=%0d done=%b err=%b hold=%b expected 0 0 1 1",
               wq.size(), o_load_done, o_load_error, o_cpu_hold);
    end
  endtask

  task automatic test_random();
    int sent;
    for (int s = 0; s < 8; s++) begin
      build($urandom_range(12), 1'($urandom_range(1)));
      model();
      do_start();
      drive(s_bytes.size(), 35, -1, sent);
      checks++;
      if (!writes_match() || sent !== m_consumed) begin
        failures++;
        $display("FAIL rand_writes s=%0d got n=%0d taken=%0d expected n=%0d taken=%0d",
                 s, wq.size(), sent, m_writes.size(), m_consumed);
      end
      checks++;
      if (o_load_done !== m_done || o_load_error !== !m_done || o_cpu_hold !== !m_done
          || (o_load_done && o_load_error) !== 1'b0) begin
        failures++;
        $display("FAIL rand_status s=%0d got done=%b err=%b hold=%b expected done=%b",
                 s, o_load_done, o_load_error, o_cpu_hold, m_done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int sent;
    build(3, 1'b1);
    model();
    do_start();
    drive(s_bytes.size(), 30, 5, sent);
    checks++;
    if (!writes_match() || o_load_done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start got writes=%0d done=%b expected writes=%0d done=1",
               wq.size(), o_load_done, m_writes.size());
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    bit  spaced;
    build(4, 1'b1);
    model();
    do_start();
    drive(s_bytes.size(), 0, -1, sent);
    spaced = (wcyc.size() == 4);
    for (int k = 1; k < wcyc.size(); k++) if (wcyc[k] - wcyc[k-1] != 2) spaced = 1'b0;
    checks++;
    if (!writes_match() || !spaced) begin
      failures++;
      $display("FAIL back_to_back got writes=%0d spacing_ok=%b expected 4 writes every 2nd cycle",
               wq.size(), spaced);
    end
  endtask

  task automatic test_full_load();
    int sent;
    build(256, 1'b1);
    model();
    do_start();
    drive(s_bytes.size(), 40, -1, sent);
    checks++;
    if (wq.size() !== 256 || wq[255][24:16] !== 9'h1FE) begin
      failures++;
      $display("FAIL full_load_count got n=%0d last_addr=%h expected 256 1fe",
               wq.size(), wq[255][24:16]);
    end
    checks++;
    if (!writes_match() || o_load_done !== 1'b1) begin
      failures++;
      $display("FAIL full_load_data got match=%b done=%b expected 1 1", writes_match(), o_load_done);
    end
  endtask

  task automatic test_reset_mid();
    int sent;
    build(2, 1'b1);
    model();
    do_start();
    drive(5, 0, -1, sent);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_cpu_hold, o_in_ready, o_imem_we} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_async got hold=%b rdy=%b we=%b expected 1 0 0",
               o_cpu_hold, o_in_ready, o_imem_we);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (wq.size() !== 1 || wq[0] !== m_writes[0]) begin
      failures++;
      $display("FAIL reset_mid_writes got n=%0d first=%h expected 1 %h", wq.size(), wq[0], m_writes[0]);
    end
    checks++;
    if ({o_in_ready, o_cpu_hold, o_load_done, o_load_error} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_mid_idle got rdy=%b hold=%b done=%b err=%b expected 0 1 0 0",
               o_in_ready, o_cpu_hold, o_load_done, o_load_error);
    end
    build(3, 1'b1);
    model();
    do_start();
    drive(s_bytes.size(), 20, -1, sent);
    checks++;
    if (!writes_match() || o_load_done !== 1'b1 || o_cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reload_after_reset got writes=%0d done=%b hold=%b expected %0d 1 0",
               wq.size(), o_load_done, o_cpu_hold, m_writes.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed_good();
    test_bad_checksum();
    test_len_overflow();
    test_zero_len();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_full_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MEM_WORDS, 256, instruction-memory depth in 16-bit words (512 B; byte address 9 bits).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  single-cycle pulse; begins a load session when in IDLE, DONE or ERR.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  loader accepts the byte; a transfer occurs when in_valid & in_ready on a rising edge.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_waddr  output  9  byte address of the written word; bit 0 always 0.
REQ-010 imem_wdata  output  16  instruction word written.
REQ-011 cpu_hold  output  1  drives the fetch-stage stall and core hold; high means the CPU must not fetch.
REQ-012 load_done  output  1  level; high after a session that completed with a good checksum.
REQ-013 load_error  output  1  level; high after a failed session.

Function
REQ-014 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
REQ-015 Stream format SHALL be: length high byte, length low byte (word count N), N words each sent high byte then low byte, then one checksum byte.
REQ-016 load_start in IDLE/DONE/ERR -> LEN_HI next cycle; clears load_done, load_error, word counter, address (0) and running checksum (0x00); sets cpu_hold.
REQ-017 load_start in LEN_HI..CHECK SHALL be ignored.
REQ-018 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK and 0 in IDLE, DONE, ERR; no other backpressure.
REQ-019 After LEN_LO accepted: N > MEM_WORDS -> ERR; N == 0 -> CHECK; else -> DATA_HI.
REQ-020 DATA_HI accept latches the high byte -> DATA_LO; DATA_LO accept -> DATA_HI, or CHECK when this was word N.
REQ-021 Running checksum SHALL be the XOR of every payload byte (not length bytes), updated on each DATA_HI/DATA_LO accept.
REQ-022 Write SHALL be registered: on the cycle after a DATA_LO accept, imem_we=1, imem_wdata={high,low}, imem_waddr=current address; address then increments by 2 (9-bit, no wrap possible since N <= MEM_WORDS).
REQ-023 imem_we SHALL be 0 in all other cycles; back-to-back words at full rate (one byte per cycle) SHALL produce a write every second cycle.
REQ-024 CHECK accept: byte == running checksum -> DONE (load_done=1, cpu_hold=0 next cycle); else -> ERR (load_error=1, cpu_hold stays 1).
REQ-025 Cycles with in_valid=0 SHALL hold state and all counters; there is no timeout.
REQ-026 load_done and load_error SHALL never be 1 simultaneously.
REQ-027 cpu_hold SHALL be 1 in every state except DONE.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, in_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, cpu_hold 1, load_done 0, load_error 0, counters and checksum 0.
REQ-029 Reset mid-session SHALL abort with no further writes; memory contents already written are not restored; a new load_start is required.
REQ-030 A write pending on the reset edge SHALL NOT be issued.

Verification
REQ-031 Load N=2: stream 00 02 12 34 AB CD, checksum 12^34^AB^CD=40 -> writes (0x000,0x1234), (0x002,0xABCD), load_done=1, cpu_hold=0.
REQ-032 Same stream with checksum 41 -> both writes occur, load_error=1, cpu_hold=1, in_ready=0.
REQ-033 Length 01 01 (257) -> ERR after second byte, zero writes.
REQ-034 Length 00 00 then checksum 00 -> DONE, zero writes; checksum 01 -> ERR.
REQ-035 N=256 full load with random in_valid gaps -> 256 writes, last address 0x1FE, no write while in_valid low mid-word.
REQ-036 rst_n low after 3 of 4 data bytes -> no further imem_we, cpu_hold=1, state IDLE; re-load after load_start succeeds.
